uart_tx_ctrl: RTL

Frame sequencer for the UART transmitter. It accepts a byte request, then drives the serializer enable, the bit index, the output-mux select and the Busy flag through the start, data, optional parity and stop phases, advancing one bit per baud tick. It sits between the host-side DATA_VALID strobe and the serializer, parity calculator and output mux. It owns the frame timing, not the data.

---
 rtl/uart_tx_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer (start/data/parity/stop timing)
// Optional second stop bit: define UART_TX_TWO_STOP_EN.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(DATA_WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TICK,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    output logic             Busy,
    output logic             load,
    output logic             ser_en,
    output logic [IDX_W-1:0] bit_idx,
    output logic [1:0]       mux_sel,
    output logic             frame_done
);

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             par_en_q, par_en_d;
    logic             load_q, load_d;
    logic             frame_done_q, frame_done_d;

    // State and registered pulses; reset abandons any frame and idles the line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            bit_idx_q    <= '0;
            par_en_q     <= 1'b0;
            load_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            par_en_q     <= par_en_d;
            load_q       <= load_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: advance one bit per TICK; TICK is ignored in IDLE.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        par_en_d     = par_en_q;
        load_d       = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (DATA_VALID) begin
                    state_d  = S_START;
                    par_en_d = PAR_EN;
                    load_d   = 1'b1;
                end
            end
            S_START: begin
                if (TICK) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (TICK) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (TICK) begin
                    state_d = S_STOP;
                end
            end
`ifdef UART_TX_TWO_STOP_EN
            S_STOP: begin
                if (TICK) begin
                    state_d = S_STOP2;
                end
            end
            S_STOP2: begin
                if (TICK) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
`else
            S_STOP: begin
                if (TICK) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode: line select, busy and serializer enable follow state only.
    always_comb begin
        Busy    = (state_q != S_IDLE);
        ser_en  = (state_q == S_DATA);
        mux_sel = 2'b11;
        case (state_q)
            S_START:  mux_sel = 2'b00;
            S_DATA:   mux_sel = 2'b01;
            S_PARITY: mux_sel = 2'b10;
            default:  mux_sel = 2'b11;
        endcase
    end

    assign bit_idx    = bit_idx_q;
    assign load       = load_q;
    assign frame_done = frame_done_q;

endmodule
